// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle two's-complement subtractor: d = a - b - bin (mod 2^WIDTH),
//   with borrow-out bout = 1 iff a < b + bin (unsigned).
//   DIGIT bits are processed per clock, starting from the LSB, so a result is
//   ready WIDTH/DIGIT cycles after the operands are accepted.
//   Valid/ready handshake on both sides; no overlap of output and input
//   handshakes (in_ready stays low while a result is waiting).
//
//   Optional feature macro: SUB_OVF_EN
//     defined   -> adds output port ovf (signed overflow, registered with d)
//     undefined -> ovf port and its logic are absent
//
//   Parameters: WIDTH (operand width), DIGIT (bits per cycle, must divide
//   WIDTH exactly, 1 <= DIGIT <= WIDTH).
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Number of digit steps per operation and the counter that tracks them.
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One digit step: {borrow_out, difference} = x - y - borrow_in.
   // The extra top bit of the (DIGIT+1)-bit result is set exactly when the
   // true difference is negative, i.e. it is the borrow out of this digit.
   function automatic logic [DIGIT:0] digit_sub(
      input logic [DIGIT-1:0] x,
      input logic [DIGIT-1:0] y,
      input logic             brw_in
   );
      logic [DIGIT:0] res;
      res = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, brw_in};
      return res;
   endfunction

   // Control state
   state_t           state_q,     state_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   // Datapath state
   logic [WIDTH-1:0] a_sh_q,      a_sh_d;
   logic [WIDTH-1:0] b_sh_q,      b_sh_d;
   logic [WIDTH-1:0] res_q,       res_d;
   logic             borrow_q,    borrow_d;

   // Published result, only updated when entering DONE
   logic [WIDTH-1:0] d_q,         d_d;
   logic             bout_q,      bout_d;

`ifdef SUB_OVF_EN
   // Operand sign bits captured at accept time for the overflow flag
   logic             a_msb_q,     a_msb_d;
   logic             b_msb_q,     b_msb_d;
   logic             ovf_q,       ovf_d;
   logic             ovf_calc_s;
`endif

   // Digit-step datapath signals
   logic [DIGIT:0]   step_s;
   logic [DIGIT-1:0] dig_s;
   logic             brw_s;
   logic [WIDTH-1:0] res_shift_s;

   // Current digit difference and borrow from the low digit of the shifters.
   always_comb begin
      step_s = digit_sub(a_sh_q[DIGIT-1:0], b_sh_q[DIGIT-1:0], borrow_q);
      dig_s  = step_s[DIGIT-1:0];
      brw_s  = step_s[DIGIT];
   end

   // New digit enters the result register at the top; older digits move
   // down, so after NDIG steps the first digit sits at the LSB.
   generate
      if (DIGIT == WIDTH) begin : g_res_full
         // Single-step operation: the digit is the whole result.
         always_comb begin
            res_shift_s = dig_s;
         end
      end else begin : g_res_shift
         // Multi-step operation: shift previous digits right by one digit.
         always_comb begin
            res_shift_s = {dig_s, res_q[WIDTH-1:DIGIT]};
         end
      end
   endgenerate

`ifdef SUB_OVF_EN
   // Signed overflow: operands of different sign and result sign differs
   // from the minuend sign. Uses the MSB of the result being completed.
   always_comb begin
      ovf_calc_s = (a_msb_q != b_msb_q) && (res_shift_s[WIDTH-1] != a_msb_q);
   end
`endif

   // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_d       = res_q;
      borrow_d    = borrow_q;
      d_d         = d_q;
      bout_d      = bout_q;
`ifdef SUB_OVF_EN
      a_msb_d     = a_msb_q;
      b_msb_d     = b_msb_q;
      ovf_d       = ovf_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               // Capture operands; they need not stay valid after this edge.
               state_d     = ST_RUN;
               in_ready_d  = 1'b0;
               out_valid_d = 1'b0;
               a_sh_d      = a;
               b_sh_d      = b;
               borrow_d    = bin;
               res_d       = '0;
               cnt_d       = '0;
`ifdef SUB_OVF_EN
               a_msb_d     = a[WIDTH-1];
               b_msb_d     = b[WIDTH-1];
`endif
            end else begin
               state_d     = ST_IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
            end
         end

         ST_RUN: begin
            // One digit per cycle; d stays at the previous result meanwhile.
            a_sh_d   = a_sh_q >> DIGIT;
            b_sh_d   = b_sh_q >> DIGIT;
            res_d    = res_shift_s;
            borrow_d = brw_s;
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               in_ready_d  = 1'b0;
               d_d         = res_shift_s;
               bout_d      = brw_s;
`ifdef SUB_OVF_EN
               ovf_d       = ovf_calc_s;
`endif
            end else begin
               state_d     = ST_RUN;
            end
         end

         ST_DONE: begin
            // Hold the result until the consumer takes it.
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               in_ready_d  = 1'b0;
            end
         end

         default: begin
            // Unreachable encoding: recover to a clean idle state.
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         borrow_q    <= 1'b0;
         d_q         <= '0;
         bout_q      <= 1'b0;
`ifdef SUB_OVF_EN
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         borrow_q    <= borrow_d;
         d_q         <= d_d;
         bout_q      <= bout_d;
`ifdef SUB_OVF_EN
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   // All outputs come straight from registers.
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign bout      = bout_q;
`ifdef SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
